vga_sync_gen: RTL

640x480 @ 60 Hz VGA timing generator for the display path. Divides the system clock down to a pixel-enable strobe, runs the horizontal and vertical pixel counters, and drives registered, active-low hsync/vsync, a visible-area flag and per-line/per-frame start pulses. `frame_start` drives the `sclr` input of the 20-bit frame-cycle `up_counter`, so that counter measures system-clock cycles within each frame: 800 × 525 × 2 = 840000 cycles, which fits in 20 bits.

---
 rtl/vga_sync_gen.sv | 91 +++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides clk to a pixel strobe, runs the h/v pixel counters and
// drives registered active-low syncs, the visible-area flag and line/frame start pulses.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       sclr,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // 11-bit bounds so a window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEG    = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_BEG    = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;

    assign tick  = (div == DIV_LAST);
    assign h_ext = {1'b0, h_next};
    assign v_ext = {1'b0, v_next};

    always_comb begin
        h_next = hcount;
        v_next = vcount;
        if (tick) begin
            if (hcount == H_LAST) begin
                h_next = 10'd0;
                v_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
            end else begin
                h_next = hcount + 10'd1;
            end
        end
    end

    // Decodes come from the next-state counts so they line up with hcount/vcount in the same clock.
    always_ff @(posedge clk) begin
        if (sclr) begin
            div         <= '0;
            pix_en      <= 1'b0;
            hcount      <= H_LAST;
            vcount      <= V_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= tick ? '0 : div + 1'b1;
            pix_en      <= tick;
            hcount      <= h_next;
            vcount      <= v_next;
            hsync       <= !((h_ext >= HS_BEG) && (h_ext < HS_END));
            vsync       <= !((v_ext >= VS_BEG) && (v_ext < VS_END));
            video_on    <= (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
            line_start  <= tick && (h_next == 10'd0);
            frame_start <= tick && (h_next == 10'd0) && (v_next == 10'd0);
        end
    end

endmodule
